// File: rtl/md_pkg.sv
// md_pkg: shared widths, iteration counts and FSM state encoding for the HI/LO multiply/divide unit.
package md_pkg;
    localparam int WORD_W     = 32;
    localparam int DIV_ITERS  = 32;
    localparam int DIV_CYCLES = 33;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_e;

    function automatic logic [WORD_W-1:0] md_neg_if(input logic [WORD_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/md_div_core.sv
// md_div_core: 32-iteration restoring divider on magnitudes; sign correction is applied combinationally on the outputs.
module md_div_core
    import md_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              usign,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    input  logic              flush,
    output logic              done,
    output logic [WORD_W-1:0] quotient,
    output logic [WORD_W-1:0] remainder
);
    logic              active_q, active_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, diff;
    logic [WORD_W:0]   shifted;
    logic              fits, a_neg, b_neg;

    assign a_neg     = ~usign & dividend[WORD_W-1];
    assign b_neg     = ~usign & divisor[WORD_W-1];
    assign done      = active_q && cnt_q == 6'(DIV_ITERS);
    assign quotient  = md_neg_if(quo_q, qneg_q);
    assign remainder = md_neg_if(rem_q, rneg_q);

    // A zero divisor needs no special case: every trial subtract succeeds, giving
    // an all-ones magnitude quotient and the dividend as remainder.
    always_comb begin
        shifted  = {rem_q, quo_q[WORD_W-1]};
        fits     = shifted >= {1'b0, dvs_q};
        diff     = shifted[WORD_W-1:0] - dvs_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            quo_d    = md_neg_if(dividend, a_neg);
            rem_d    = '0;
            dvs_d    = md_neg_if(divisor, b_neg);
            qneg_d   = a_neg ^ b_neg;
            rneg_d   = a_neg;
        end else if (flush || done) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            rem_d = fits ? diff : shifted[WORD_W-1:0];
            quo_d = {quo_q[WORD_W-2:0], fits};
            cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end
endmodule

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: multiply/divide unit owning HI/LO with a busy stall flag.
// Optional MD_DIV0_FLAG_EN adds a one-cycle div0 pulse when a divide-by-zero result is written.
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DATA_W     = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_mul,
    input  logic              start_div,
    input  logic              usign,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic              flush,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
`ifdef MD_DIV0_FLAG_EN
    ,output logic             div0
`endif
);
    md_state_e         state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, quo, rem;
    logic [63:0]       prod_q, prod_d, mul_a, mul_b;
    logic [3:0]        cnt_q, cnt_d;
    logic              idle_ok, acc_mul, acc_div, div_done, op_end;

    assign idle_ok = state_q == MD_IDLE && !flush;
    assign acc_mul = idle_ok && start_mul;
    assign acc_div = idle_ok && !start_mul && start_div;
    assign op_end  = state_q == MD_DIV && !flush && div_done;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = state_q != MD_IDLE;

    // Extending by an extra sign-or-zero bit lets one signed multiply serve mult and multu.
    assign mul_a = 64'($signed({~usign & src_a[DATA_W-1], src_a}));
    assign mul_b = 64'($signed({~usign & src_b[DATA_W-1], src_b}));

    md_div_core u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (acc_div),
        .usign     (usign),
        .dividend  (src_a),
        .divisor   (src_b),
        .flush     (flush),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (acc_mul) begin
            state_d = MD_MUL;
            prod_d  = mul_a * mul_b;
            cnt_d   = 4'(MUL_CYCLES - 1);
        end else if (acc_div) begin
            state_d = MD_DIV;
        end else if (idle_ok) begin
            hi_d = mthi ? src_a : hi_q;
            lo_d = mtlo ? src_a : lo_q;
        end
        if (state_q != MD_IDLE && flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else if (state_q == MD_MUL) begin
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
            state_d = cnt_q == '0 ? MD_IDLE : MD_MUL;
            hi_d    = cnt_q == '0 ? prod_q[63:32] : hi_q;
            lo_d    = cnt_q == '0 ? prod_q[31:0] : lo_q;
        end else if (op_end) begin
            state_d = MD_IDLE;
            hi_d    = rem;
            lo_d    = quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MD_DIV0_FLAG_EN
    logic div0_op_q, div0_op_d, div0_q, div0_d;
    always_comb begin
        div0_op_d = acc_div ? src_b == '0 : div0_op_q;
        div0_d    = op_end && div0_op_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div0_op_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            div0_op_q <= div0_op_d;
            div0_q    <= div0_d;
        end
    end
    assign div0 = div0_q;
`endif
endmodule

// File: tb/tb_md_hilo_unit.sv
// tb_md_hilo_unit: table-driven mult/div vectors plus hand sequences for flush, ignore-while-busy, mthi/mtlo and async reset.
module tb_md_hilo_unit;
    import md_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_mul = 1'b0, start_div = 1'b0, usign = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
    logic [31:0] src_a = '0, src_b = '0, hi, lo;
    logic        busy;
    int          tests = 0, failed = 0;
`ifdef MD_DIV0_FLAG_EN
    logic        div0;
    int          div0_cnt = 0;
    always @(negedge clk) if (div0) div0_cnt++;
`endif

    md_hilo_unit #(.MUL_CYCLES(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mul (start_mul),
        .start_div (start_div),
        .usign     (usign),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .flush     (flush),
        .src_a     (src_a),
        .src_b     (src_b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
`ifdef MD_DIV0_FLAG_EN
        ,.div0     (div0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mul;
        logic        us;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;
    vec_t v[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input logic m, input logic d, input logic us, input logic [31:0] a,
                      input logic [31:0] b, output int lat);
        @(negedge clk);
        start_mul = m;
        start_div = d;
        usign     = us;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        #1;
        start_mul = 1'b0;
        start_div = 1'b0;
        lat = 0;
        while (busy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_mul = m;
        start_div = d;
        usign     = 1'b0;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        #1;
        start_mul = 1'b0;
        start_div = 1'b0;
    endtask

    task automatic move_to(input logic h, input logic l, input logic [31:0] a);
        @(negedge clk);
        mthi  = h;
        mtlo  = l;
        src_a = a;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        int lat;
        v[0]  = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        v[1]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[2]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        v[3]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[4]  = '{1'b1, 1'b1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        v[5]  = '{1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        v[6]  = '{1'b0, 1'b1, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        v[7]  = '{1'b0, 1'b0, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'h00000001};
        v[8]  = '{1'b0, 1'b0, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        v[9]  = '{1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[10] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        v[11] = '{1'b0, 1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        v[12] = '{1'b0, 1'b1, 32'd1000,     32'd7,        32'h00000006, 32'h0000008E};
        v[13] = '{1'b0, 1'b0, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        v[14] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            go(v[i].mul, ~v[i].mul, v[i].us, v[i].a, v[i].b, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), v[i].mul ? 32'd4 : 32'(DIV_CYCLES));
            chk($sformatf("vec%0d hi", i), hi, v[i].eh);
            chk($sformatf("vec%0d lo", i), lo, v[i].el);
        end

        // multu with a divide request presented while busy: the divide must be dropped
        @(negedge clk);
        start_mul = 1'b1;
        usign     = 1'b1;
        src_a     = 32'hFFFFFFFF;
        src_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start_mul = 1'b0;
        start_div = 1'b1;
        src_a     = 32'd5;
        src_b     = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        start_div = 1'b0;
        @(posedge clk);
        #1;
        chk("mul busy at E0+3", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        chk("mul busy at E0+4", 32'(busy), 32'h0);
        chk("multu hi", hi, 32'hFFFFFFFE);
        chk("multu lo", lo, 32'h00000001);
        @(posedge clk);
        #1;
        chk("ignored div no busy", 32'(busy), 32'h0);

        go(1'b1, 1'b1, 1'b0, 32'd6, 32'd7, lat);
        chk("mul over div latency", 32'(lat), 32'd4);
        chk("mul over div lo", lo, 32'd42);

        move_to(1'b1, 1'b1, 32'h5A5A5A5A);
        chk("mthi+mtlo hi", hi, 32'h5A5A5A5A);
        chk("mthi+mtlo lo", lo, 32'h5A5A5A5A);
        chk("mthi+mtlo busy", 32'(busy), 32'h0);
        move_to(1'b1, 1'b0, 32'h11111111);
        move_to(1'b0, 1'b1, 32'h22222222);
        chk("mthi hi", hi, 32'h11111111);
        chk("mtlo lo", lo, 32'h22222222);

        // divide-by-zero flushed after ten cycles: no write, no div0 pulse
        start_op(1'b0, 1'b1, 32'd100, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'h0);
        chk("flush hi", hi, 32'h11111111);
        chk("flush lo", lo, 32'h22222222);
        repeat (40) @(posedge clk);
        #1;
        chk("post-flush hi", hi, 32'h11111111);
        chk("post-flush lo", lo, 32'h22222222);
        go(1'b0, 1'b1, 1'b1, 32'd9, 32'd3, lat);
        chk("div after flush latency", 32'(lat), 32'(DIV_CYCLES));
        chk("div after flush lo", lo, 32'd3);
        chk("div after flush hi", hi, 32'd0);

        @(negedge clk);
        start_mul = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        start_mul = 1'b0;
        flush     = 1'b0;
        chk("idle flush suppresses", 32'(busy), 32'h0);

        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        mthi  = 1'b1;
        src_a = 32'hAAAAAAAA;
        repeat (3) @(posedge clk);
        #1;
        mthi = 1'b0;
        @(posedge clk);
        #1;
        chk("mthi during mul busy", 32'(busy), 32'h0);
        chk("mthi during mul hi", hi, 32'h0);
        chk("mthi during mul lo", lo, 32'd12);

        move_to(1'b0, 1'b1, 32'hDEADBEEF);
        chk("mtlo lo", lo, 32'hDEADBEEF);
        chk("mtlo keeps hi", hi, 32'h0);

        start_op(1'b0, 1'b1, 32'd50, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset hi", hi, 32'h0);
        chk("async reset lo", lo, 32'h0);
        chk("async reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("after reset lo", lo, 32'h0);
`ifdef MD_DIV0_FLAG_EN
        chk("div0 pulse count", 32'(div0_cnt), 32'd3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
